// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Purpose:
//   Parses register-write command frames arriving byte-by-byte from a UART
//   receiver. A frame is HEADER, addr, data[, csum]. An accepted frame produces
//   a one-cycle wr_en strobe with wr_addr/wr_data holding the frame contents.
//   Checksum mismatches and inter-byte timeouts produce a one-cycle frame_err
//   pulse and bump a saturating error counter.
//
// Configuration macro:
//   UART_CMD_CSUM_EN  defined   -> 4-byte frame, last byte is (addr+data) mod 256
//                     undefined -> 3-byte frame, no checksum, errors only from
//                                  inter-byte timeout (default build)
//
// Parameters:
//   CLK        system clock frequency in Hz
//   BPS        UART bit rate
//   HEADER     frame start byte
//   TMO_BYTES  inter-byte timeout in UART character times (10 bits each)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx_data    received byte, valid when rx_done=1
//   rx_done    one-cycle strobe marking a received byte
//   wr_en      one-cycle register-write strobe
//   wr_addr    address of the last accepted frame (held between commits)
//   wr_data    data of the last accepted frame (held between commits)
//   frame_err  one-cycle error pulse (checksum mismatch or timeout)
//   err_cnt    saturating count of frame_err pulses
//   busy       high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int unsigned CLK       = 200_000_000,
    parameter int unsigned BPS       = 115200,
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int unsigned TMO_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    // Timeout length in clock cycles; the counter trips when it reaches the
    // last cycle of this window without a new byte arriving.
    localparam int unsigned TMO_CYC  = TMO_BYTES * 32'd10 * (CLK / BPS);
    localparam logic [31:0] TMO_LAST = 32'(TMO_CYC - 32'd1);

`ifdef UART_CMD_CSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    // Frame checksum: modulo-256 sum of address and data.
    function automatic logic [7:0] calc_csum(input logic [7:0] a, input logic [7:0] d);
        calc_csum = a + d;
    endfunction
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;
`endif

    state_t      state_r;
    state_t      state_s;
    logic [31:0] tmo_cnt_r;
    logic [31:0] tmo_cnt_s;
    logic [7:0]  addr_r;
    logic [7:0]  addr_s;
    logic [7:0]  data_r;
    logic [7:0]  data_s;
    logic        wr_en_r;
    logic        commit_s;
    logic [7:0]  wr_addr_r;
    logic [7:0]  wr_addr_s;
    logic [7:0]  wr_data_r;
    logic [7:0]  wr_data_s;
    logic        frame_err_r;
    logic        error_s;
    logic [7:0]  err_cnt_r;
    logic [7:0]  err_cnt_s;
    logic        busy_r;
    logic        busy_s;

    // Next-state, timeout and output decode for the frame FSM.
    always_comb begin
        state_s   = state_r;
        tmo_cnt_s = tmo_cnt_r;
        addr_s    = addr_r;
        data_s    = data_r;
        commit_s  = 1'b0;
        error_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;

        case (state_r)
            IDLE: begin
                // Anything other than HEADER is silently dropped here.
                if (rx_done && (rx_data == HEADER)) begin
                    state_s = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                // HEADER value is ordinary payload once inside a frame.
                if (rx_done) begin
                    addr_s  = rx_data;
                    state_s = DATA;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (rx_done) begin
                    data_s = rx_data;
`ifdef UART_CMD_CSUM_EN
                    state_s = CSUM;
`else
                    // No checksum byte: the data byte completes the frame.
                    commit_s  = 1'b1;
                    wr_addr_s = addr_r;
                    wr_data_s = rx_data;
                    state_s   = IDLE;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_CMD_CSUM_EN
            CSUM: begin
                if (rx_done) begin
                    if (rx_data == calc_csum(addr_r, data_r)) begin
                        commit_s  = 1'b1;
                        wr_addr_s = addr_r;
                        wr_data_s = data_r;
                    end else begin
                        error_s = 1'b1;
                    end
                    state_s = IDLE;
                end else begin
                    state_s = CSUM;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase

        // Inter-byte timeout. A byte arriving on the expiry cycle takes
        // priority, so the frame keeps going and no error is raised.
        if (state_r == IDLE) begin
            tmo_cnt_s = 32'd0;
        end else if (rx_done) begin
            tmo_cnt_s = 32'd0;
        end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_cnt_s = 32'd0;
            state_s   = IDLE;
            error_s   = 1'b1;
        end else begin
            tmo_cnt_s = tmo_cnt_r + 32'd1;
        end

        if (error_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_s = err_cnt_r;
        end

        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            tmo_cnt_r   <= 32'd0;
            addr_r      <= 8'd0;
            data_r      <= 8'd0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= 8'd0;
            wr_data_r   <= 8'd0;
            frame_err_r <= 1'b0;
            err_cnt_r   <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            tmo_cnt_r   <= tmo_cnt_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            wr_en_r     <= commit_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            frame_err_r <= error_s;
            err_cnt_r   <= err_cnt_s;
            busy_r      <= busy_s;
        end
    end

    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign frame_err = frame_err_r;
    assign err_cnt   = err_cnt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Scoreboard bench for uart_cmd_parser. Stimulus pushes the expected write or
// error event into a queue before driving the bytes; a monitor on the falling
// clock edge pops and compares whenever wr_en or frame_err is high.
// Parameters are scaled so one timeout window is 60 cycles.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int unsigned TB_CLK = 200_000;
    localparam int unsigned TB_BPS = 100_000;
    localparam int unsigned TB_TMO = 3;
    localparam int unsigned TMO_CYC = 60;   // 3 * 10 * (200000/100000)
    localparam logic [7:0]  HDR = 8'hA5;

    typedef struct {
        bit         is_err;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_err  = 8'd0;
    logic [7:0] last_a   = 8'd0;
    logic [7:0] last_d   = 8'd0;

    uart_cmd_parser #(
        .CLK       (TB_CLK),
        .BPS       (TB_BPS),
        .HEADER    (HDR),
        .TMO_BYTES (TB_TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; drives one rx_done pulse and returns at the next one.
    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_write(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d; e.cnt = exp_err;
        sb_q.push_back(e);
        last_a = a;
        last_d = d;
    endtask

    task automatic push_err();
        exp_t e;
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        e.is_err = 1'b1; e.addr = last_a; e.data = last_d; e.cnt = exp_err;
        sb_q.push_back(e);
    endtask

    // ok=0 only makes sense with the checksum byte present.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input bit ok);
        if (ok) push_write(a, d);
        else    push_err();
        put(HDR);
        put(a);
        put(d);
`ifdef UART_CMD_CSUM_EN
        put(c);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_err = 8'd0;
        last_a  = 8'd0;
        last_d  = 8'd0;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && frame_err) begin
                chk("wr_en_and_frame_err", 32'd1, 32'd0);
            end
            if (wr_en || frame_err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", {31'd0, frame_err}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("event_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                    chk("event_wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                    chk("event_wr_data", {24'd0, wr_data}, {24'd0, e.data});
                    chk("event_err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        rx_data = 8'd0;
        rx_done = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic good frame; busy must drop afterwards.
        send_frame(8'h10, 8'h3C, 8'h4C, 1'b1);
        idle(2);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);

`ifdef UART_CMD_CSUM_EN
        // Bad checksum: error, write registers untouched.
        send_frame(8'h10, 8'h3C, 8'h00, 1'b0);
        idle(2);
        chk("hold_addr_after_err", {24'd0, wr_addr}, 32'h10);
        chk("hold_data_after_err", {24'd0, wr_data}, 32'h3C);
`endif

        // Back-to-back frames, HEADER value used as payload.
        send_frame(8'hA5, 8'h5A, 8'hFF, 1'b1);
        send_frame(8'h00, 8'hFF, 8'hFF, 1'b1);
        send_frame(8'hFF, 8'h01, 8'h00, 1'b1);
        send_frame(8'h7F, 8'h80, 8'hFF, 1'b1);
        idle(2);

        // Junk byte ignored, partial frame times out exactly on cycle TMO_CYC.
        push_err();
        put(8'h55);
        chk("busy_after_junk", {31'd0, busy}, 32'd0);
        put(HDR);
        put(8'h22);
        idle(TMO_CYC - 1);
        chk("busy_before_tmo", {31'd0, busy}, 32'd1);
        idle(1);
        chk("busy_after_tmo", {31'd0, busy}, 32'd0);
        chk("err_cnt_after_tmo", {24'd0, err_cnt}, {24'd0, exp_err});
        idle(2);

        // Byte arriving on the expiry cycle wins over the timeout.
        push_write(8'h33, 8'h44);
        put(HDR);
        idle(TMO_CYC - 1);
        put(8'h33);
        put(8'h44);
`ifdef UART_CMD_CSUM_EN
        put(8'h77);
`endif
        idle(2);
        chk("drain_before_rst", sb_q.size(), 32'd0);

        // Reset mid-frame discards the frame silently.
        put(HDR);
        put(8'h10);
        do_reset();
        send_frame(8'h01, 8'h02, 8'h03, 1'b1);
        idle(2);

        // Error counter saturates at 255 rather than wrapping.
        for (int i = 0; i < 300; i++) begin
            push_err();
            put(HDR);
            idle(TMO_CYC);
        end
        idle(2);
        chk("err_cnt_saturated", {24'd0, err_cnt}, 32'hFF);

        idle(5);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
